// File: rtl/sw_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// sw_input_conditioner_pkg
// Shared constants for the switch/sensor input conditioner and the blocks that
// consume its outputs (traffic-light controller, BCD clock).
//   - default debounce length and default channel/counter geometry
//   - symbolic indices of the board switch channels
// No ports (package).
// -----------------------------------------------------------------------------
package sw_input_conditioner_pkg;

   // Default number of consecutive fast-clock cycles a synchronised input must
   // disagree with the debounced level before the level flips.
   localparam int DEFAULT_STABLE_CYCLES = 65536;

   // Default geometry of the conditioner instance on the board.
   localparam int DEFAULT_N_CH  = 4;
   localparam int DEFAULT_CNT_W = 8;

   // Which conditioned channel feeds which function downstream.
   typedef enum logic [1:0] {
      SW_RESET   = 2'd0,
      SW_ENA     = 2'd1,
      SW_SENSOR1 = 2'd2,
      SW_SENSOR2 = 2'd3
   } swChannelE;

   // Bit offset of a channel's edge counter inside the packed count bus.
   function automatic int countLsb(input int channel, input int cntWidth);
      return channel * cntWidth;
   endfunction

endpackage

// File: rtl/sw_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// sw_input_conditioner_if
// Bundles the conditioner's data signals so the board top can pass them as one
// port.  Clock and reset are kept as plain ports on the modules.
// Signals:
//   raw_i    [N_CH]         raw asynchronous switch/sensor inputs
//   cnt_clr                 synchronous clear of all edge counters
//   level_o  [N_CH]         debounced level per channel
//   rise_o   [N_CH]         one-cycle pulse when level goes 0->1
//   fall_o   [N_CH]         one-cycle pulse when level goes 1->0
//   count_o  [N_CH*CNT_W]   per-channel rising-edge count, channel c at
//                           [c*CNT_W +: CNT_W]
// Modports:
//   master   the side that supplies raw inputs and consumes clean outputs
//   slave    the conditioner itself
// -----------------------------------------------------------------------------
interface sw_input_conditioner_if
   import sw_input_conditioner_pkg::*;
#(
   parameter int N_CH  = DEFAULT_N_CH,
   parameter int CNT_W = DEFAULT_CNT_W
);

   logic [N_CH-1:0]       raw_i;
   logic                  cnt_clr;
   logic [N_CH-1:0]       level_o;
   logic [N_CH-1:0]       rise_o;
   logic [N_CH-1:0]       fall_o;
   logic [N_CH*CNT_W-1:0] count_o;

   modport master (
      output raw_i,
      output cnt_clr,
      input  level_o,
      input  rise_o,
      input  fall_o,
      input  count_o
   );

   modport slave (
      input  raw_i,
      input  cnt_clr,
      output level_o,
      output rise_o,
      output fall_o,
      output count_o
   );

endinterface

// File: rtl/sw_input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One bit of the input conditioner: two-flop synchroniser, counter-based
// debounce, registered clean level and registered one-cycle rise/fall pulses.
// Parameters:
//   STABLE_CYCLES  consecutive clocks the synchronised input must differ from
//                  the level before the level flips (>= 2)
// Ports:
//   clk       in   board clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   i_raw     in   raw asynchronous input
//   o_level   out  debounced level
//   o_rise    out  one-cycle pulse in the first cycle o_level shows 1
//   o_fall    out  one-cycle pulse in the first cycle o_level shows 0
// -----------------------------------------------------------------------------
module debounce_channel
   import sw_input_conditioner_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
)(
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic [CW-1:0] r_cnt;

   logic          w_differs;
   logic          w_flip;

   // Two-flop synchroniser; nothing downstream ever looks at r_sync1 or the
   // raw pin directly, only at r_sync2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // The level flips on the cycle the disagreement has lasted STABLE_CYCLES
   // clocks; the counter saturates at LAST and is then consumed by the flip.
   assign w_differs = (r_sync2 != r_level);
   assign w_flip    = w_differs && (r_cnt == LAST);

   // Debounce counter, clean level and edge pulses.  Any cycle where the
   // synchronised input agrees with the level restarts the count, so a glitch
   // shorter than STABLE_CYCLES never reaches o_level.  The pulses are set on
   // the same edge as the level so they line up with its first new cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= w_flip &&  r_sync2;
         r_fall <= w_flip && !r_sync2;
         if (w_flip) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else if (w_differs) begin
            r_cnt   <= r_cnt + CW'(1);
         end else begin
            r_cnt   <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/sw_input_conditioner.sv
// -----------------------------------------------------------------------------
// sw_input_conditioner
// Conditions the raw board switch/sensor pins before they reach the
// traffic-light controller and BCD clock.  Runs on the fast board clock, ahead
// of the clock divider.  Each channel is an independent debounce_channel; the
// optional per-channel rising-edge counters live here.
// Optional feature macro:
//   SW_COND_EDGE_COUNT_EN  when defined, builds saturating rising-edge counters
//                          cleared by cnt_clr; when undefined, count_o is tied
//                          to 0 and cnt_clr is ignored.  Ports are identical.
// Parameters:
//   N_CH           number of input channels
//   STABLE_CYCLES  debounce length in clocks (>= 2)
//   CNT_W          width of each edge counter
// Ports:
//   clk       in   board clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   bus       slave modport of sw_input_conditioner_if (raw_i, cnt_clr in;
//             level_o, rise_o, fall_o, count_o out)
// -----------------------------------------------------------------------------
module sw_input_conditioner
   import sw_input_conditioner_pkg::*;
#(
   parameter int N_CH          = DEFAULT_N_CH,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = DEFAULT_CNT_W
)(
   input  logic                  clk,
   input  logic                  reset_n,
   sw_input_conditioner_if.slave bus
);

   logic [N_CH-1:0] w_level;
   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_fall;

   // One fully independent conditioner per channel, so simultaneous edges on
   // several channels all come out in the same cycle.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .i_raw   (bus.raw_i[c]),
         .o_level (w_level[c]),
         .o_rise  (w_rise[c]),
         .o_fall  (w_fall[c])
      );
   end

   assign bus.level_o = w_level;
   assign bus.rise_o  = w_rise;
   assign bus.fall_o  = w_fall;

`ifdef SW_COND_EDGE_COUNT_EN

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_CH*CNT_W-1:0] r_count;

   // Saturating rising-edge counters.  The clear is checked first so that a
   // clear arriving in the same cycle as a rise pulse leaves the count at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (bus.cnt_clr) begin
         r_count <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_rise[c] && (r_count[countLsb(c, CNT_W) +: CNT_W] != CNT_MAX)) begin
               r_count[countLsb(c, CNT_W) +: CNT_W] <=
                  r_count[countLsb(c, CNT_W) +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   assign bus.count_o = r_count;

`else

   logic w_unusedClr;

   // Counter build disabled: keep the port shape, drive zeros, and swallow
   // the clear input.
   assign bus.count_o = {(N_CH*CNT_W){1'b0}};
   assign w_unusedClr = bus.cnt_clr;

`endif

endmodule
